sram_port_arbiter: RTL and testbench

- Shares the single SRAM controller between two 32-bit memory requesters: port 0 (CPU MEM stage) and port 1 (loader/debug master).
- Each requester sees a simple request/ack interface. The arbiter sequences exactly one controller transaction per grant and returns read data with a one-cycle ack.
- Sits between the MEM stage, the loader port and the SRAM controller's wr_en/rd_en/address/writeData/readData/ready interface.

---
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: one controller
// transaction per grant, latched request copy, one-cycle ack with read data.
module sram_port_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_rd_en,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_writeData,
  output logic [31:0] p0_readData,
  output logic        p0_ack,
  input  logic        p1_rd_en,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_writeData,
  output logic [31:0] p1_readData,
  output logic        p1_ack,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData,
  input  logic        mem_ready,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  req_t        lat, win_req;
  logic        last_grant, grant, req0, req1, any_req;
  logic [31:0] rdata;
  logic [7:0]  tcnt, tcnt_inc;
  logic        ready_ok, wd_hit, to_err;

  assign req0    = p0_rd_en | p0_wr_en;
  assign req1    = p1_rd_en | p1_wr_en;
  assign any_req = req0 | req1;

  // grant = 1 selects port 1; a tie in round-robin goes to the port not served last
  always_comb begin
    if (PRIORITY_MODE == 1)  grant = !req0;
    else if (req0 && req1)   grant = !last_grant;
    else                     grant = !req0;
  end

  // rd_en together with wr_en is a write
  assign win_req = grant ? {1'b1, p1_wr_en, p1_address, p1_writeData}
                         : {1'b0, p0_wr_en, p0_address, p0_writeData};

  assign tcnt_inc = tcnt + 8'd1;
  assign ready_ok = (tcnt != '0) && mem_ready;
  assign wd_hit   = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    p0_ack        = 1'b0;
    p1_ack        = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        busy          = 1'b1;
        mem_wr_en     = lat.wr;
        mem_rd_en     = !lat.wr;
        mem_address   = lat.addr;
        mem_writeData = lat.data;
        if (ready_ok || wd_hit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        p0_ack    = !lat.id;
        p1_ack    = lat.id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a completing ready wins over a watchdog hit in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lat        <= '0;
      last_grant <= 1'b1;
      rdata      <= '0;
      tcnt       <= '0;
      to_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          lat        <= win_req;
          last_grant <= grant;
          tcnt       <= '0;
        end
        ISSUE: begin
          tcnt <= tcnt_inc;
          if (ready_ok) rdata <= mem_readData;
          else if (wd_hit) begin
            rdata  <= '0;
            to_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign p0_readData = p0_ack ? rdata : '0;
  assign p1_readData = p1_ack ? rdata : '0;
  assign timeout_err = to_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: requester and controller models
// drive the DUT, a cycle-level scoreboard predicts every output.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_rd_en = 0, p0_wr_en = 0, p1_rd_en = 0, p1_wr_en = 0;
  logic [31:0] p0_address = 0, p0_writeData = 0, p1_address = 0, p1_writeData = 0;
  logic [31:0] p0_readData, p1_readData, mem_address, mem_writeData;
  logic        p0_ack, p1_ack, mem_wr_en, mem_rd_en, busy, timeout_err;
  logic [31:0] mem_readData = 0;
  logic        mem_ready = 0;

  sram_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_address(p0_address),
    .p0_writeData(p0_writeData), .p0_readData(p0_readData), .p0_ack(p0_ack),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_address(p1_address),
    .p1_writeData(p1_writeData), .p1_readData(p1_readData), .p1_ack(p1_ack),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  // fixed-priority instance behind an always-ready controller
  logic        f_p0_rd_en = 0, f_p1_rd_en = 0;
  logic [31:0] f_p0_readData, f_p1_readData, f_mem_address, f_mem_writeData, f_mem_readData;
  logic        f_p0_ack, f_p1_ack, f_mem_wr_en, f_mem_rd_en, f_busy, f_timeout_err, f_mem_ready;
  assign f_mem_ready    = 1'b1;
  assign f_mem_readData = f_mem_address ^ 32'hA5A50000;

  sram_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) u_fix (
    .clk(clk), .rst(rst),
    .p0_rd_en(f_p0_rd_en), .p0_wr_en(1'b0), .p0_address(32'h10),
    .p0_writeData(32'h0), .p0_readData(f_p0_readData), .p0_ack(f_p0_ack),
    .p1_rd_en(f_p1_rd_en), .p1_wr_en(1'b0), .p1_address(32'h20),
    .p1_writeData(32'h0), .p1_readData(f_p1_readData), .p1_ack(f_p1_ack),
    .mem_wr_en(f_mem_wr_en), .mem_rd_en(f_mem_rd_en), .mem_address(f_mem_address),
    .mem_writeData(f_mem_writeData), .mem_readData(f_mem_readData), .mem_ready(f_mem_ready),
    .busy(f_busy), .timeout_err(f_timeout_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: phase 0 = idle, 1 = controller transaction, 2 = ack cycle
  int          cyc = 0, phase = 0, win = 0, last_w = 1, cnt = 0, t_grant = 0;
  logic        l_wr = 0, exp_to = 0;
  logic [31:0] l_addr = 0, l_data = 0, exp_data = 0;
  logic [31:0] cmem[8], rmem[8];
  // requesters
  bit          act[2], wdn[2];
  logic        rd[2], wr[2];
  logic [31:0] ad[2], dt[2];
  int          quiet[2];
  bit          rnd = 0, auto_renew = 0, stall = 0;
  int          fix_lat = 3, en_cnt = 0, lat = 0;

  function automatic logic [31:0] rnd_addr();
    return 32'h400 + ($urandom_range(0, 7) << 2);
  endfunction

  task automatic drive();
    p0_rd_en = act[0] & rd[0];  p0_wr_en = act[0] & wr[0];
    p0_address = ad[0];         p0_writeData = dt[0];
    p1_rd_en = act[1] & rd[1];  p1_wr_en = act[1] & wr[1];
    p1_address = ad[1];         p1_writeData = dt[1];
  endtask

  task automatic set_txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    act[p] = 1; rd[p] = !w; wr[p] = w; ad[p] = a; dt[p] = d;
    drive();
  endtask

  task automatic new_txn(input int p);
    int op;
    op = $urandom_range(0, 3);
    act[p] = 1; rd[p] = (op != 2); wr[p] = (op >= 2);
    ad[p] = rnd_addr(); dt[p] = $urandom;
  endtask

  // move the scoreboard across the posedge that just happened
  task automatic advance();
    bit r0, r1;
    r0 = p0_rd_en | p0_wr_en;
    r1 = p1_rd_en | p1_wr_en;
    case (phase)
      0: if (r0 || r1) begin
        win    = (r0 && r1) ? 1 - last_w : (r0 ? 0 : 1);
        last_w = win;
        l_wr   = (win == 1) ? p1_wr_en : p0_wr_en;
        l_addr = (win == 1) ? p1_address : p0_address;
        l_data = (win == 1) ? p1_writeData : p0_writeData;
        cnt = 0; t_grant = cyc - 1; phase = 1;
      end
      1: begin
        cnt++;
        if (cnt >= 2 && mem_ready) begin
          exp_data = l_wr ? mem_readData : rmem[l_addr[4:2]];
          if (l_wr) rmem[l_addr[4:2]] = l_data;
          phase = 2;
        end else if (cnt == 16) begin
          exp_data = 0; exp_to = 1; phase = 2;
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic upd_req(input int p);
    if (phase == 2 && win == p) begin
      wdn[p] = 0;
      if (auto_renew || (rnd && $urandom_range(0, 1) == 1)) new_txn(p);
      else begin act[p] = 0; quiet[p] = $urandom_range(0, 3); end
    end else if (rnd && phase == 1 && win == p && act[p]) begin
      case ($urandom_range(0, 7))
        0: begin act[p] = 0; wdn[p] = 1; end
        1: begin ad[p] = rnd_addr(); dt[p] = $urandom; end
        default: ;
      endcase
    end else if (rnd && !act[p] && !wdn[p]) begin
      if (quiet[p] == 0) new_txn(p);
      else quiet[p]--;
    end
  endtask

  task automatic step();
    bit en, real_rdy;
    @(negedge clk);
    cyc++;
    advance();
    chk("busy", busy, phase != 0);
    chk("mem_rd_en", mem_rd_en, phase == 1 && !l_wr);
    chk("mem_wr_en", mem_wr_en, phase == 1 && l_wr);
    if (phase == 1) begin
      chk("mem_address", mem_address, l_addr);
      if (l_wr) chk("mem_writeData", mem_writeData, l_data);
    end
    chk("p0_ack", p0_ack, phase == 2 && win == 0);
    chk("p1_ack", p1_ack, phase == 2 && win == 1);
    chk("p0_readData", p0_readData, (phase == 2 && win == 0) ? exp_data : 32'h0);
    chk("p1_readData", p1_readData, (phase == 2 && win == 1) ? exp_data : 32'h0);
    chk("timeout_err", timeout_err, exp_to);
    if (phase == 2 && fix_lat == 3 && !exp_to) chk("ack_latency", cyc - t_grant, 4);
    // controller: ready on its lat-th enabled cycle, sometimes a spurious first-cycle ready
    en = mem_rd_en | mem_wr_en;
    en_cnt = en ? en_cnt + 1 : 0;
    if (en_cnt == 1) lat = (fix_lat != 0) ? fix_lat : $urandom_range(2, 5);
    real_rdy = en && !stall && en_cnt == lat;
    mem_ready = real_rdy || (en && !stall && en_cnt == 1 && $urandom_range(0, 3) == 0);
    mem_readData = $urandom;
    if (real_rdy) begin
      if (mem_wr_en) cmem[mem_address[4:2]] = mem_writeData;
      else mem_readData = cmem[mem_address[4:2]];
    end
    for (int p = 0; p < 2; p++) upd_req(p);
    drive();
  endtask

  task automatic reset_dut();
    rst = 1; act[0] = 0; act[1] = 0; wdn[0] = 0; wdn[1] = 0; drive();
    mem_ready = 0;
    @(negedge clk);
    cyc++;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writeData", mem_writeData, 0);
    chk("rst_acks", {p0_ack, p1_ack}, 0);
    chk("rst_readData", p0_readData | p1_readData, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 0; phase = 0; last_w = 1; exp_to = 0; en_cnt = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (phase == 0 && !act[0] && !act[1]) break;
      step();
    end
    chk("drain", phase == 0 && !act[0] && !act[1], 1);
  endtask

  task automatic to_issue();
    for (int n = 0; n < 10 && phase != 1; n++) step();
    chk("reach_issue", phase, 1);
  endtask

  task automatic fix_wait(output bit got);
    got = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (f_p0_ack || f_p1_ack) begin got = 1; break; end
    end
  endtask

  initial begin
    int  n0, n1;
    bit  got;
    for (int i = 0; i < 8; i++) begin cmem[i] = $urandom; rmem[i] = cmem[i]; end
    cmem[0] = 32'hDEADBEEF; rmem[0] = 32'hDEADBEEF;
    reset_dut();

    // directed: p0 read, p1 write, read-back
    set_txn(0, 0, 32'h400, 0);          drain();
    set_txn(1, 1, 32'h404, 32'h12345678); drain();
    set_txn(0, 0, 32'h404, 0);          drain();

    // both requesting continuously: alternating grants, one ack per 5 cycles
    auto_renew = 1;
    set_txn(0, 0, 32'h408, 0);
    set_txn(1, 1, 32'h40C, 32'hCAFE0001);
    n0 = 0; n1 = 0;
    repeat (40) begin step(); n0 += int'(p0_ack); n1 += int'(p1_ack); end
    chk("rr_p0_acks", n0, 4);
    chk("rr_p1_acks", n1, 4);
    auto_renew = 0;
    drain();

    // request withdrawn and address changed mid-transaction
    set_txn(0, 0, 32'h408, 0);
    to_issue();
    step();
    act[0] = 0; ad[0] = 32'h41C; drive();
    drain();

    // controller never ready: watchdog abort, sticky error
    stall = 1;
    set_txn(0, 0, 32'h40C, 0); drain();
    stall = 0;
    set_txn(1, 1, 32'h410, 32'h0BADF00D); drain();

    // randomized traffic
    rnd = 1; fix_lat = 0; quiet[0] = 0; quiet[1] = 0;
    repeat (1500) step();
    rnd = 0; fix_lat = 3;
    drain();

    // reset during ISSUE, then first tie after reset goes to port 0
    set_txn(1, 1, 32'h414, 32'h55AA55AA);
    to_issue();
    step();
    reset_dut();
    set_txn(0, 0, 32'h414, 0);
    set_txn(1, 0, 32'h400, 0);
    step();
    chk("tie_after_rst", win, 0);
    drain();

    // fixed priority: p0 always wins while requesting
    @(negedge clk);
    f_p0_rd_en = 1; f_p1_rd_en = 1;
    for (int k = 0; k < 4; k++) begin
      fix_wait(got);
      chk("fix_ack_seen", got, 1);
      chk("fix_p0_ack", f_p0_ack, 1);
      chk("fix_p1_ack", f_p1_ack, 0);
      chk("fix_p0_data", f_p0_readData, 32'hA5A50010);
      if (k == 3) f_p0_rd_en = 0;
    end
    fix_wait(got);
    chk("fix_ack_seen", got, 1);
    chk("fix_p1_served", f_p1_ack, 1);
    chk("fix_p1_data", f_p1_readData, 32'hA5A50020);
    f_p1_rd_en = 0;
    chk("fix_timeout_err", f_timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
